decode_ctrl_stage: RTL and testbench

DECODE_CTRL_STAGE -- requirements
Module: decode_ctrl_stage

---
 rtl/decode_ctrl_stage.sv | 191 +++++++++++++++++++
 tb/tb_decode_ctrl_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl_stage.sv
// ============================================================================
// Module   : decode_ctrl_stage
// Purpose  : ID stage control decode with load-use stall detection.
// Revision : 1.0
// ============================================================================
`default_nettype none

module decode_ctrl_stage #(
    parameter int INST_W = 32,
    parameter int REG_AW = 5,
    parameter int IMM_W  = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_inst_valid,
    input  logic [INST_W-1:0] i_inst,
    output logic              o_stall,
    output logic              o_ex_valid,
    output logic              o_we_st,
    output logic              o_we_r,
    output logic              o_ma,
    output logic [REG_AW-1:0] o_destAddr,
    output logic [3:0]        o_aluControl,
    output logic [IMM_W-1:0]  o_addr,
    output logic              o_Cin,
    output logic              o_illegal,
    output logic [CNT_W-1:0]  o_stall_cnt
);

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [3:0] c_ALU_ADD  = 4'b0010;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic              r_ex_valid, r_we_st, r_we_r, r_ma, r_cin, r_illegal;
    logic [REG_AW-1:0] r_dest;
    logic [3:0]        r_alu;
    logic [IMM_W-1:0]  r_addr;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_ex_valid, w_we_st, w_we_r, w_ma, w_cin, w_illegal;
    logic [REG_AW-1:0] w_dest;
    logic [3:0]        w_alu;
    logic [IMM_W-1:0]  w_addr;

    logic [5:0]        w_op;
    logic [REG_AW-1:0] w_rs, w_rt, w_rd;
    logic              w_uses_rt;
    logic              w_hazard;
    logic              w_stall;

    assign w_op      = i_inst[31:26];
    assign w_rs      = REG_AW'(i_inst[25:21]);
    assign w_rt      = REG_AW'(i_inst[20:16]);
    assign w_rd      = REG_AW'(i_inst[15:11]);
    assign w_uses_rt = (w_op == c_OP_RTYPE) || (w_op == c_OP_SW);

    // Load-use: the instruction in ID reads the register a load in EX is about to fill.
    assign w_hazard = i_inst_valid && r_ex_valid && r_ma && (r_dest != '0) &&
                      ((w_rs == r_dest) || (w_uses_rt && (w_rt == r_dest)));

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_stall = w_hazard && !i_flush && !rst;
                if (w_stall) begin
                    w_state_nxt = ST_STALL;
                end
            end
            ST_STALL: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_comb begin
        w_ex_valid = 1'b0;
        w_we_st    = 1'b0;
        w_we_r     = 1'b0;
        w_ma       = 1'b0;
        w_cin      = 1'b0;
        w_illegal  = 1'b0;
        w_dest     = '0;
        w_alu      = '0;
        w_addr     = '0;
        if (!i_flush && !w_stall && i_inst_valid) begin
            case (w_op)
                c_OP_RTYPE: begin
                    w_ex_valid = 1'b1;
                    w_we_r     = 1'b1;
                    w_dest     = w_rd;
                    w_alu      = i_inst[3:0];
                    w_cin      = i_inst[4];
                    w_addr     = i_inst[IMM_W-1:0];
                end
                c_OP_LW: begin
                    w_ex_valid = 1'b1;
                    w_we_r     = 1'b1;
                    w_ma       = 1'b1;
                    w_dest     = w_rt;
                    w_alu      = c_ALU_ADD;
                    w_addr     = i_inst[IMM_W-1:0];
                end
                c_OP_SW: begin
                    w_ex_valid = 1'b1;
                    w_we_st    = 1'b1;
                    w_dest     = w_rt;
                    w_alu      = c_ALU_ADD;
                    w_addr     = i_inst[IMM_W-1:0];
                end
                c_OP_ADDI: begin
                    w_ex_valid = 1'b1;
                    w_we_r     = 1'b1;
                    w_dest     = w_rt;
                    w_alu      = c_ALU_ADD;
                    w_addr     = i_inst[IMM_W-1:0];
                end
                default: begin
                    w_illegal = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid  <= 1'b0;
            r_we_st     <= 1'b0;
            r_we_r      <= 1'b0;
            r_ma        <= 1'b0;
            r_cin       <= 1'b0;
            r_illegal   <= 1'b0;
            r_dest      <= '0;
            r_alu       <= '0;
            r_addr      <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_ex_valid <= w_ex_valid;
            r_we_st    <= w_we_st;
            r_we_r     <= w_we_r;
            r_ma       <= w_ma;
            r_cin      <= w_cin;
            r_illegal  <= w_illegal;
            r_dest     <= w_dest;
            r_alu      <= w_alu;
            r_addr     <= w_addr;
            if (w_stall && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign o_stall      = w_stall;
    assign o_ex_valid   = r_ex_valid;
    assign o_we_st      = r_we_st;
    assign o_we_r       = r_we_r;
    assign o_ma         = r_ma;
    assign o_destAddr   = r_dest;
    assign o_aluControl = r_alu;
    assign o_addr       = r_addr;
    assign o_Cin        = r_cin;
    assign o_illegal    = r_illegal;
    assign o_stall_cnt  = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_decode_ctrl_stage.sv
// ============================================================================
// Module   : tb_decode_ctrl_stage
// Purpose  : Directed-vector bench for decode_ctrl_stage against a rule model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_decode_ctrl_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        ivalid = 1'b0;
    logic [31:0] inst = '0;

    logic        a_stall, a_v, a_st, a_r, a_ma, a_cin, a_ill;
    logic [4:0]  a_dest;
    logic [3:0]  a_alu;
    logic [15:0] a_addr;
    logic [15:0] a_cnt;

    logic        b_stall, b_v, b_st, b_r, b_ma, b_cin, b_ill;
    logic [4:0]  b_dest;
    logic [3:0]  b_alu;
    logic [15:0] b_addr;
    logic [1:0]  b_cnt;

    always #5 clk = ~clk;

    decode_ctrl_stage dut (
        .clk(clk), .rst(rst), .i_flush(flush), .i_inst_valid(ivalid), .i_inst(inst),
        .o_stall(a_stall), .o_ex_valid(a_v), .o_we_st(a_st), .o_we_r(a_r), .o_ma(a_ma),
        .o_destAddr(a_dest), .o_aluControl(a_alu), .o_addr(a_addr), .o_Cin(a_cin),
        .o_illegal(a_ill), .o_stall_cnt(a_cnt)
    );

    decode_ctrl_stage #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .i_flush(flush), .i_inst_valid(ivalid), .i_inst(inst),
        .o_stall(b_stall), .o_ex_valid(b_v), .o_we_st(b_st), .o_we_r(b_r), .o_ma(b_ma),
        .o_destAddr(b_dest), .o_aluControl(b_alu), .o_addr(b_addr), .o_Cin(b_cin),
        .o_illegal(b_ill), .o_stall_cnt(b_cnt)
    );

    typedef struct packed {
        logic        v, st, r, ma, cin, ill;
        logic [4:0]  dest;
        logic [3:0]  alu;
        logic [15:0] addr;
    } bundle_t;

    typedef struct {
        logic        rst, flush, valid;
        logic [31:0] inst;
    } vec_t;

    vec_t    vecs[$];
    int      n_vec  = 0;
    int      n_fail = 0;
    bundle_t m      = '0;
    int      m_cnt  = 0;
    int      m_cnt2 = 0;
    bit      m_known = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic bundle_t decode(input logic [31:0] x);
        bundle_t b = '0;
        case (x[31:26])
            6'h00: begin b.v = 1; b.r = 1; b.dest = x[15:11]; b.alu = x[3:0]; b.cin = x[4]; end
            6'h23: begin b.v = 1; b.r = 1; b.ma = 1; b.dest = x[20:16]; b.alu = 4'd2; end
            6'h2B: begin b.v = 1; b.st = 1; b.dest = x[20:16]; b.alu = 4'd2; end
            6'h08: begin b.v = 1; b.r = 1; b.dest = x[20:16]; b.alu = 4'd2; end
            default: b.ill = 1;
        endcase
        if (b.v) b.addr = x[15:0];
        return b;
    endfunction

    // A consumer of a pending load's destination must wait one cycle.
    function automatic bit model_stall();
        bit reads_rt;
        if (rst || flush || !ivalid) return 1'b0;
        if (!(m.v && m.ma && m.dest != 0)) return 1'b0;
        reads_rt = (inst[31:26] == 6'h00) || (inst[31:26] == 6'h2B);
        return (inst[25:21] == m.dest) || (reads_rt && inst[20:16] == m.dest);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m       <= '0;
            m_cnt   <= 0;
            m_cnt2  <= 0;
            m_known <= 1'b1;
        end else if (flush || !ivalid) begin
            m <= '0;
        end else if (model_stall()) begin
            m      <= '0;
            m_cnt  <= (m_cnt  < 65535) ? m_cnt  + 1 : m_cnt;
            m_cnt2 <= (m_cnt2 < 3)     ? m_cnt2 + 1 : m_cnt2;
        end else begin
            m <= decode(inst);
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            chk("stall",    a_stall, model_stall());
            chk("ex_valid", a_v,     m.v);
            chk("we_st",    a_st,    m.st);
            chk("we_r",     a_r,     m.r);
            chk("ma",       a_ma,    m.ma);
            chk("Cin",      a_cin,   m.cin);
            chk("illegal",  a_ill,   m.ill);
            chk("destAddr", a_dest,  m.dest);
            chk("aluCtl",   a_alu,   m.alu);
            chk("addr",     a_addr,  m.addr);
            chk("stall_cnt", a_cnt,  m_cnt);
            chk("sat.stall", b_stall, model_stall());
            chk("sat.bundle", {b_v, b_st, b_r, b_ma, b_cin, b_ill, b_dest, b_alu, b_addr},
                              {m.v, m.st, m.r, m.ma, m.cin, m.ill, m.dest, m.alu, m.addr});
            chk("sat.stall_cnt", b_cnt, m_cnt2);
        end
    end

    task automatic add(input logic r, input logic f, input logic v, input logic [31:0] x);
        vec_t e;
        e.rst = r; e.flush = f; e.valid = v; e.inst = x;
        vecs.push_back(e);
    endtask

    // Hand-derived expectations at fixed vector indices, independent of the model.
    task automatic lit(input int k);
        case (k)
            2:  begin chk("L.rst_v", a_v, 0); chk("L.rst_cnt", a_cnt, 0);
                      chk("L.rst_stall", a_stall, 0); chk("L.rst_dest", a_dest, 0); end
            4:  begin chk("L.add_v", a_v, 1); chk("L.add_wr", a_r, 1);
                      chk("L.add_dest", a_dest, 3); chk("L.add_alu", a_alu, 0); chk("L.add_cin", a_cin, 0); end
            6:  begin chk("L.r_alu", a_alu, 5); chk("L.r_cin", a_cin, 1); end
            7:  begin chk("L.addi_dest", a_dest, 3); chk("L.addi_addr", a_addr, 5); chk("L.addi_alu", a_alu, 2); end
            8:  begin chk("L.lw_stall", a_stall, 1); chk("L.lw_ma", a_ma, 1); chk("L.lw_dest", a_dest, 2); end
            9:  begin chk("L.held_stall", a_stall, 0); chk("L.bubble_v", a_v, 0); end
            10: begin chk("L.issue_dest", a_dest, 3); chk("L.issue_v", a_v, 1); chk("L.cnt1", a_cnt, 1); end
            12: chk("L.sw_stall", a_stall, 1);
            13: chk("L.sw_held", a_stall, 0);
            14: begin chk("L.sw_st", a_st, 1); chk("L.sw_dest", a_dest, 2); chk("L.cnt2", a_cnt, 2); end
            16: chk("L.r0_nostall", a_stall, 0);
            18: chk("L.flush_stall", a_stall, 0);
            19: begin chk("L.flush_v", a_v, 0); chk("L.flush_cnt", a_cnt, 2); end
            20: begin chk("L.ill_pulse", a_ill, 1); chk("L.ill_v", a_v, 0); end
            21: chk("L.ill_clear", a_ill, 0);
            37: begin chk("L.cnt7", a_cnt, 7); chk("L.sat3", b_cnt, 3); end
            39: chk("L.rst_midstall", a_stall, 0);
            40: begin chk("L.post_rst_stall", a_stall, 0); chk("L.post_rst_cnt", a_cnt, 0); end
            41: begin chk("L.reissue_dest", a_dest, 3); chk("L.reissue_v", a_v, 1); end
            default: ;
        endcase
    endtask

    initial begin
        add(1, 0, 0, 32'h0);          // 0
        add(1, 0, 0, 32'h0);          // 1
        add(0, 0, 0, 32'h0);          // 2
        add(0, 0, 1, 32'h00A41820);   // 3  add $3,$5,$4
        add(0, 0, 0, 32'h0);          // 4
        add(0, 0, 1, 32'h00A41835);   // 5  R-type alu=5, Cin=1
        add(0, 0, 1, 32'h20430005);   // 6  addi $3,$2,5
        add(0, 0, 1, 32'h8C220004);   // 7  lw $2,4($1)
        add(0, 0, 1, 32'h00431820);   // 8  uses $2 -> stall
        add(0, 0, 1, 32'h00431820);   // 9  held
        add(0, 0, 0, 32'h0);          // 10
        add(0, 0, 1, 32'h8C220004);   // 11
        add(0, 0, 1, 32'hAC620000);   // 12 sw rt=$2 -> stall
        add(0, 0, 1, 32'hAC620000);   // 13
        add(0, 0, 0, 32'h0);          // 14
        add(0, 0, 1, 32'h8C200004);   // 15 lw $0
        add(0, 0, 1, 32'h00001820);   // 16 uses $0
        add(0, 0, 1, 32'h8C220004);   // 17
        add(0, 1, 1, 32'h00431820);   // 18 flush on hazard
        add(0, 0, 1, 32'hFC000000);   // 19 illegal
        add(0, 0, 0, 32'h0);          // 20
        add(0, 0, 0, 32'h0);          // 21
        for (int i = 0; i < 5; i++) begin   // 22..36
            add(0, 0, 1, 32'h8C220004);
            add(0, 0, 1, 32'h00431820);
            add(0, 0, 1, 32'h00431820);
        end
        add(0, 0, 0, 32'h0);          // 37
        add(0, 0, 1, 32'h8C220004);   // 38
        add(1, 0, 1, 32'h00431820);   // 39 reset mid-hazard
        add(0, 0, 1, 32'h00431820);   // 40 re-presented
        add(0, 0, 0, 32'h0);          // 41
        add(0, 0, 0, 32'h0);          // 42

        for (int k = 0; k < vecs.size(); k++) begin
            @(posedge clk);
            #1;
            rst    = vecs[k].rst;
            flush  = vecs[k].flush;
            ivalid = vecs[k].valid;
            inst   = vecs[k].inst;
            @(negedge clk);
            lit(k);
        end
        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
